// File: rtl/smart_home_pkg.sv
// ---------------------------------------------------------------------------
// smart_home_pkg
// Shared types for the smart-home conditioning and lighting stages.
//   occ_state_t  : occupancy FSM state (IDLE/CONFIRM/OCCUPIED/HOLD)
//   OCC_*        : numeric encodings, for blocks that see the state as a
//                  plain 2-bit bus
//   is_occupied  : 1 for the states in which the room counts as occupied
// ---------------------------------------------------------------------------
package smart_home_pkg;

    localparam logic [1:0] OCC_IDLE     = 2'd0;
    localparam logic [1:0] OCC_CONFIRM  = 2'd1;
    localparam logic [1:0] OCC_OCCUPIED = 2'd2;
    localparam logic [1:0] OCC_HOLD     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = OCC_IDLE,
        CONFIRM  = OCC_CONFIRM,
        OCCUPIED = OCC_OCCUPIED,
        HOLD     = OCC_HOLD
    } occ_state_t;

    // Occupied means the lights should be on: confirmed motion, or the
    // hold-off period after motion stopped.
    function automatic logic is_occupied(input occ_state_t s);
        return (s == OCCUPIED) || (s == HOLD);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-cycle timing tick every DIV clocks.
// The counter runs 0..DIV-1 and tick is high during the cycle at DIV-1, so
// the first tick after reset is seen by the clock edge that ends cycle DIV.
// With DIV=1 tick is permanently high.
//   clk   in  1  system clock
//   rst   in  1  asynchronous, active-high reset (counter to 0)
//   tick  out 1  one-cycle strobe at counter wrap
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/motion_occupancy.sv
// ---------------------------------------------------------------------------
// motion_occupancy
// Conditions a raw PIR detector for the lighting stage: two-flop
// synchroniser, tick-based debounce before declaring motion, and a
// programmable hold time after motion stops so the lights do not drop out
// between PIR pulses. A manual vacancy pulse forces IDLE and locks out
// re-detection until the PIR has been seen low once.
//
// Ports
//   clk           in   1  system clock
//   rst           in   1  asynchronous, active-high reset
//   pirRaw        in   1  raw PIR output, asynchronous to clk
//   manualOff     in   1  single-cycle vacancy pulse
//   motionSensor  out  1  registered occupancy flag (OCCUPIED or HOLD)
//   occState      out  2  current FSM state (IDLE=0 CONFIRM=1 OCCUPIED=2 HOLD=3)
//   eventCount    out  8  only with MOTION_EVENT_COUNT_EN: saturating count of
//                         entries into OCCUPIED from CONFIRM or HOLD
//
// Build option: define MOTION_EVENT_COUNT_EN to add the eventCount port.
// ---------------------------------------------------------------------------
module motion_occupancy
    import smart_home_pkg::*;
#(
    parameter int TICK_DIV       = 50,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int HOLD_TICKS     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pirRaw,
    input  logic       manualOff,
    output logic       motionSensor,
    output logic [1:0] occState
`ifdef MOTION_EVENT_COUNT_EN
    ,
    output logic [7:0] eventCount
`endif
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_TICKS);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    // ---------------------------------------------------------------
    // Synchroniser: the FSM only ever looks at pir_s_reg.
    // ---------------------------------------------------------------
    logic pir_meta_reg;
    logic pir_s_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pir_meta_reg <= 1'b0;
            pir_s_reg    <= 1'b0;
        end else begin
            pir_meta_reg <= pirRaw;
            pir_s_reg    <= pir_meta_reg;
        end
    end

    // ---------------------------------------------------------------
    // Timing tick. The prescaler is free-running so tick phase is
    // independent of when the FSM changes state; this is what makes the
    // debounce and hold latencies a one-tick window rather than exact.
    // ---------------------------------------------------------------
    logic tick;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ---------------------------------------------------------------
    // FSM state and counters
    // ---------------------------------------------------------------
    occ_state_t    state_reg,    state_next;
    logic [DW-1:0] deb_cnt_reg,  deb_cnt_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic          lockout_reg,  lockout_next;
    logic          motion_reg,   motion_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            deb_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            lockout_reg  <= 1'b0;
            motion_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            deb_cnt_reg  <= deb_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            lockout_reg  <= lockout_next;
            motion_reg   <= motion_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        deb_cnt_next  = deb_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        lockout_next  = lockout_reg;

        if (manualOff) begin
            // Vacancy override. Lockout keeps a PIR that is still high from
            // immediately re-occupying the room.
            state_next    = IDLE;
            deb_cnt_next  = '0;
            hold_cnt_next = '0;
            lockout_next  = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (lockout_reg) begin
                        if (!pir_s_reg) begin
                            lockout_next = 1'b0;
                        end
                    end else if (pir_s_reg) begin
                        state_next   = CONFIRM;
                        deb_cnt_next = '0;
                    end
                end

                CONFIRM: begin
                    if (!pir_s_reg) begin
                        state_next = IDLE;
                    end else if (tick) begin
                        // The tick that brings the count to DEBOUNCE_TICKS
                        // also confirms; the count saturates there.
                        if (deb_cnt_reg >= DEB_LAST) begin
                            deb_cnt_next = DEB_MAX;
                            state_next   = OCCUPIED;
                        end else begin
                            deb_cnt_next = deb_cnt_reg + DW'(1);
                        end
                    end
                end

                OCCUPIED: begin
                    if (!pir_s_reg) begin
                        state_next    = HOLD;
                        hold_cnt_next = HOLD_MAX;
                    end
                end

                HOLD: begin
                    // Retrigger is checked first so it wins over expiry on
                    // the final tick; no re-debounce is needed here.
                    if (pir_s_reg) begin
                        state_next = OCCUPIED;
                    end else if (tick) begin
                        if (hold_cnt_reg <= HOLD_ONE) begin
                            hold_cnt_next = '0;
                            state_next    = IDLE;
                        end else begin
                            hold_cnt_next = hold_cnt_reg - HW'(1);
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output decode: motionSensor is registered from the next state so it
    // changes on the same edge as occState.
    always_comb begin
        motion_next = is_occupied(state_next);
    end

    assign motionSensor = motion_reg;
    assign occState     = state_reg;

`ifdef MOTION_EVENT_COUNT_EN
    // ---------------------------------------------------------------
    // Occupancy event counter: counts fresh confirmations and retriggers.
    // ---------------------------------------------------------------
    logic [7:0] event_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_cnt_reg <= 8'd0;
        end else if ((state_reg == CONFIRM || state_reg == HOLD) &&
                     state_next == OCCUPIED &&
                     event_cnt_reg != 8'hFF) begin
            event_cnt_reg <= event_cnt_reg + 8'd1;
        end
    end

    assign eventCount = event_cnt_reg;
`endif

endmodule
